// File: rtl/nbcac_16di_decode_sched.sv
// rtl/nbcac_16di_decode_sched.sv - round-robin scheduler sharing one NB-CAC decoder core among NCH channels
// Optional range check on the decoded sum: define NBCAC_DECODE_RANGE_CHECK_EN.

module nbcac_16di_decoder_core (
    input  logic [23:1] d,
    output logic [15:0] v
);
    // Fibonacci-like weight set; the value wraps modulo 2^16 by construction of v's width.
    localparam logic [15:0] W [1:23] = '{
        16'd1,    16'd35422, 16'd21892, 16'd13530, 16'd8362, 16'd5168,
        16'd3194, 16'd1974,  16'd1220,  16'd754,   16'd466,  16'd288,
        16'd178,  16'd110,   16'd68,    16'd42,    16'd26,   16'd16,
        16'd10,   16'd6,     16'd4,     16'd2,     16'd2
    };

    always_comb begin
        v = '0;
        for (int k = 1; k <= 23; k++) begin
            if (d[k]) begin
                v = v + W[k];
            end
        end
    end
endmodule

module nbcac_16di_decode_sched #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH-1:0]     in_valid,
    output logic [NCH-1:0]     in_ready,
    input  logic [NCH*23-1:0]  in_cw,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_v,
    output logic [CHW-1:0]     out_ch,
    output logic               out_err,
    output logic               busy
);
    logic           a_valid_q, a_valid_d;
    logic [22:0]    a_cw_q,    a_cw_d;
    logic [CHW-1:0] a_ch_q,    a_ch_d;
    logic [CHW-1:0] rr_ptr_q,  rr_ptr_d;
    logic           out_valid_q, out_valid_d;
    logic [15:0]    out_v_q,   out_v_d;
    logic [CHW-1:0] out_ch_q,  out_ch_d;

    logic [NCH-1:0] grant;
    logic [CHW-1:0] grant_ch;
    logic           arb_hit;
    int             arb_idx;
    logic           b_take;
    logic           a_ready;
    logic           accept;
    logic [15:0]    core_v;

    nbcac_16di_decoder_core u_core (
        .d (a_cw_q),
        .v (core_v)
    );

    // First requester at or after rr_ptr, wrapping at NCH (not at 2^CHW).
    always_comb begin
        grant    = '0;
        grant_ch = '0;
        arb_hit  = 1'b0;
        arb_idx  = 0;
        for (int i = 0; i < NCH; i++) begin
            arb_idx = (int'(rr_ptr_q) + i) % NCH;
            if (!arb_hit && in_valid[arb_idx]) begin
                grant[arb_idx] = 1'b1;
                grant_ch       = arb_idx[CHW-1:0];
                arb_hit        = 1'b1;
            end
        end
    end

    assign b_take   = a_valid_q & (~out_valid_q | out_ready);
    assign a_ready  = ~a_valid_q | b_take;
    assign in_ready = (rst_n && a_ready) ? grant : '0;
    assign accept   = |(in_valid & in_ready);

`ifdef NBCAC_DECODE_RANGE_CHECK_EN
    localparam logic [15:0] RC_W [23] = '{
        16'd1,    16'd35422, 16'd21892, 16'd13530, 16'd8362, 16'd5168,
        16'd3194, 16'd1974,  16'd1220,  16'd754,   16'd466,  16'd288,
        16'd178,  16'd110,   16'd68,    16'd42,    16'd26,   16'd16,
        16'd10,   16'd6,     16'd4,     16'd2,     16'd2
    };

    logic [16:0] shadow_sum;
    logic        out_err_q, out_err_d;

    // Unwrapped 17-bit sum; anything above 16 bits means the codeword was out of range.
    always_comb begin
        shadow_sum = '0;
        for (int k = 0; k < 23; k++) begin
            if (a_cw_q[k]) begin
                shadow_sum = shadow_sum + {1'b0, RC_W[k]};
            end
        end
    end

    always_comb begin
        out_err_d = out_err_q;
        if (b_take) begin
            out_err_d = (shadow_sum > 17'd65535);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_err_q <= 1'b0;
        end else begin
            out_err_q <= out_err_d;
        end
    end

    assign out_err = out_err_q;
`else
    assign out_err = 1'b0;
`endif

    always_comb begin
        a_valid_d   = a_valid_q;
        a_cw_d      = a_cw_q;
        a_ch_d      = a_ch_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_v_d     = out_v_q;
        out_ch_d    = out_ch_q;

        if (accept) begin
            a_valid_d = 1'b1;
            a_cw_d    = in_cw[int'(grant_ch)*23 +: 23];
            a_ch_d    = grant_ch;
            rr_ptr_d  = (int'(grant_ch) == NCH-1) ? '0 : grant_ch + CHW'(1);
        end else if (b_take) begin
            a_valid_d = 1'b0;
        end

        if (b_take) begin
            out_valid_d = 1'b1;
            out_v_d     = core_v;
            out_ch_d    = a_ch_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_valid_q   <= 1'b0;
            a_cw_q      <= '0;
            a_ch_q      <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_v_q     <= '0;
            out_ch_q    <= '0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_cw_q      <= a_cw_d;
            a_ch_q      <= a_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_v_q     <= out_v_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_v     = out_v_q;
    assign out_ch    = out_ch_q;
    assign busy      = a_valid_q | out_valid_q;
endmodule

// File: tb/tb_nbcac_16di_decode_sched.sv
// tb/tb_nbcac_16di_decode_sched.sv - self-checking bench for nbcac_16di_decode_sched

module tb_nbcac_16di_decode_sched;
    localparam int NCH = 4;
    localparam int CHW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   in_valid;
    logic [NCH-1:0]   in_ready;
    logic [NCH*23-1:0] in_cw;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_v;
    logic [CHW-1:0]   out_ch;
    logic             out_err;
    logic             busy;

    nbcac_16di_decode_sched #(.NCH(NCH), .CHW(CHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cw     (in_cw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_v     (out_v),
        .out_ch    (out_ch),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [22:0] cw;
        logic [15:0] exp_v;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [15:0]    v;
        logic [CHW-1:0] ch;
        logic           err;
    } res_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   w [23];
    res_t sbq [$];
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int model_sum(input logic [22:0] cw);
        int s = 0;
        for (int k = 0; k < 23; k++) begin
            if (cw[k]) s += w[k];
        end
        return s;
    endfunction

    function automatic logic model_err(input logic [22:0] cw);
`ifdef NBCAC_DECODE_RANGE_CHECK_EN
        return model_sum(cw) > 65535;
`else
        return 1'b0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on accept, pop on consume, both sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got out_v %0d ch %0d, expected no result", out_v, out_ch);
                end else begin
                    res_t e;
                    e = sbq.pop_front();
                    check("sb_v", 32'(out_v), 32'(e.v));
                    check("sb_ch", 32'(out_ch), 32'(e.ch));
                    check("sb_err", 32'(out_err), 32'(e.err));
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    res_t r;
                    logic [22:0] cw;
                    cw   = in_cw[i*23 +: 23];
                    r.v  = 16'(model_sum(cw));
                    r.ch = CHW'(i);
                    r.err = model_err(cw);
                    sbq.push_back(r);
                end
            end
        end
    end

    logic [22:0] cw1;
    logic        exp_err_ones;

    initial begin
        w[0]  = 1;
        w[22] = 2;
        w[21] = 2;
        for (int j = 20; j >= 1; j--) w[j] = w[j+1] + w[j+2];

`ifdef NBCAC_DECODE_RANGE_CHECK_EN
        exp_err_ones = 1'b1;
`else
        exp_err_ones = 1'b0;
`endif
        vecs[0] = '{0, 23'h000001, 16'd1,     1'b0};
        vecs[1] = '{2, 23'h000002, 16'd35422, 1'b0};
        vecs[2] = '{1, 23'h000004, 16'd21892, 1'b0};
        vecs[3] = '{3, 23'h7FFFFF, 16'd27199, exp_err_ones};
        vecs[4] = '{0, 23'h400000, 16'd2,     1'b0};
        vecs[5] = '{2, 23'h000003, 16'd35423, 1'b0};

        rst_n     = 1'b0;
        in_valid  = '0;
        in_cw     = '0;
        out_ready = 1'b1;
        step();
        step();
        in_valid = '1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = '0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_v", 32'(out_v), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        step();
        rst_n = 1'b1;

        // Single-word decodes with 2-cycle latency.
        foreach (vecs[i]) begin
            in_valid = NCH'(1) << vecs[i].ch;
            in_cw[vecs[i].ch*23 +: 23] = vecs[i].cw;
            #1;
            check("tbl_grant", 32'(in_ready), 32'(NCH'(1) << vecs[i].ch));
            step();
            in_valid = '0;
            check("tbl_lat1_valid", 32'(out_valid), 32'd0);
            check("tbl_lat1_busy", 32'(busy), 32'd1);
            step();
            check("tbl_out_valid", 32'(out_valid), 32'd1);
            check("tbl_out_v", 32'(out_v), 32'(vecs[i].exp_v));
            check("tbl_out_ch", 32'(out_ch), 32'(vecs[i].ch));
            check("tbl_out_err", 32'(out_err), 32'(vecs[i].exp_err));
            step();
            check("tbl_drained", 32'(out_valid), 32'd0);
        end

        // Round-robin order, then a one-cycle drop on channel 1 at pointer 1.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        in_valid = '1;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < NCH; i++) in_cw[i*23 +: 23] = 23'($urandom);
            #1;
            check("rr_order", 32'(in_ready), 32'(NCH'(1) << (c % NCH)));
            step();
        end
        in_valid = 4'b1101;
        #1;
        check("rr_skip1", 32'(in_ready), 32'b0100);
        step();
        in_valid = '1;
        #1;
        check("rr_ptr3", 32'(in_ready), 32'b1000);
        step();
        #1;
        check("rr_wrap0", 32'(in_ready), 32'b0001);
        step();
        in_valid = '0;
        step();
        step();
        check("rr_idle", 32'(busy), 32'd0);

        // Backpressure: pointer is at 1 here.
        for (int i = 0; i < NCH; i++) in_cw[i*23 +: 23] = 23'(32'h1234 * (i + 3));
        cw1 = in_cw[1*23 +: 23];
        in_valid  = '1;
        out_ready = 1'b0;
        #1;
        check("bp_grant1", 32'(in_ready), 32'b0010);
        step();
        #1;
        check("bp_grant2", 32'(in_ready), 32'b0100);
        step();
        for (int c = 0; c < 4; c++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_hold_v", 32'(out_v), 32'(16'(model_sum(cw1))));
            check("bp_hold_ch", 32'(out_ch), 32'd1);
            if (c < 3) step();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        step();
        check("bp_drain_ch", 32'(out_ch), 32'd2);
        step();
        check("bp_empty", 32'(busy), 32'd0);
        check("bp_sb_empty", 32'(sbq.size()), 32'd0);

        // Reset with both stages full.
        in_valid  = '1;
        out_ready = 1'b0;
        step();
        step();
        check("mr_full_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        step();
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("mr_first_grant", 32'(in_ready), 32'b0001);
        step();
        in_valid  = '0;
        out_ready = 1'b1;
        step();
        step();
        check("mr_drained", 32'(busy), 32'd0);

        // Random traffic under random backpressure.
        for (int c = 0; c < 400; c++) begin
            in_valid  = NCH'($urandom);
            for (int i = 0; i < NCH; i++) in_cw[i*23 +: 23] = 23'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        check("rand_busy", 32'(busy), 32'd0);
        check("rand_sb_empty", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
